// File: rtl/mux16_rr_scheduler_pkg.sv
// Shared constants and state type for the 16:1 mux scheduler.
// Optional statistics outputs are enabled by MUX16_SCHED_STATS_EN.
package mux16_sched_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

endpackage

// File: rtl/mux16_rr_scheduler_if.sv
// Requester <-> scheduler bundle for the 16:1 mux.
// Optional stats signals exist only with MUX16_SCHED_STATS_EN.
interface mux16_rr_scheduler_if;
    import mux16_sched_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [SEL_W-1:0] sel;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
`ifdef MUX16_SCHED_STATS_EN
    logic             timeout;
    logic [15:0]      grant_cnt;

    modport master (
        output req, done,
        input  sel, gnt, gnt_valid, timeout, grant_cnt
    );
    modport slave (
        input  req, done,
        output sel, gnt, gnt_valid, timeout, grant_cnt
    );
`else
    modport master (
        output req, done,
        input  sel, gnt, gnt_valid
    );
    modport slave (
        input  req, done,
        output sel, gnt, gnt_valid
    );
`endif

endinterface

// File: rtl/mux16_rr_scheduler_rr_pick16.sv
// Round-robin search: first set request at or after ptr, wrapping.
// Purely combinational.
module rr_pick16
    import mux16_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux16_rr_scheduler.sv
// Round-robin arbiter/sequencer for the shared 16:1 mux output.
// Build with MUX16_SCHED_STATS_EN for timeout and grant_cnt outputs.
module mux16_rr_scheduler
    import mux16_sched_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux16_rr_scheduler_if.slave  bus
);

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [SEL_W-1:0] sel_q;
    logic [N_REQ-1:0] gnt_q;
    logic             gv_q;
    logic             found;
    logic [SEL_W-1:0] idx;
    logic             expired;
    logic             release_now;

    rr_pick16 u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .found (found),
        .idx   (idx)
    );

    assign expired     = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign release_now = bus.done | ~bus.req[sel_q] | expired;

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gv_q;

`ifdef MUX16_SCHED_STATS_EN
    logic        timeout_q;
    logic [15:0] grant_cnt_q;

    assign bus.timeout   = timeout_q;
    assign bus.grant_cnt = grant_cnt_q;
`endif

    // Grant FSM: pick in IDLE, hold until release, then one idle bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            sel_q    <= '0;
            gnt_q    <= '0;
            gv_q     <= 1'b0;
`ifdef MUX16_SCHED_STATS_EN
            timeout_q   <= 1'b0;
            grant_cnt_q <= '0;
`endif
        end else begin
`ifdef MUX16_SCHED_STATS_EN
            timeout_q <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (found) begin
                        sel_q    <= idx;
                        gnt_q    <= N_REQ'(1) << idx;
                        gv_q     <= 1'b1;
                        hold_cnt <= '0;
                        state    <= GRANT;
`ifdef MUX16_SCHED_STATS_EN
                        if (grant_cnt_q != 16'hFFFF)
                            grant_cnt_q <= grant_cnt_q + 16'd1;
`endif
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt_q    <= '0;
                        gv_q     <= 1'b0;
                        ptr      <= sel_q + SEL_W'(1);
                        hold_cnt <= '0;
                        state    <= IDLE;
`ifdef MUX16_SCHED_STATS_EN
                        timeout_q <= ~bus.done & bus.req[sel_q];
`endif
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Directed self-checking bench for mux16_rr_scheduler.
// Stats checks compile in with MUX16_SCHED_STATS_EN.
module tb_mux16_rr_scheduler;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mux16_rr_scheduler_if bus ();

    mux16_rr_scheduler #(
        .MAX_HOLD (8),
        .HOLD_W   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] k);
        logic [15:0] g;
        g = 16'h0001 << k;
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, "_sel"}, 32'(bus.sel), 32'(k));
        chk({tag, "_gv"}, 32'(bus.gnt_valid), 32'd1);
    endtask

    task automatic chk_bubble(input string tag, input logic [3:0] k);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        chk({tag, "_gv"}, 32'(bus.gnt_valid), 32'd0);
        chk({tag, "_sel"}, 32'(bus.sel), 32'(k));
    endtask

    // Starting in grant cycle 1: done pulsed in cycle 3, ends in bubble.
    task automatic run3(input string tag, input logic [3:0] k);
        chk_grant({tag, "_c1"}, k);
        tick();
        chk_grant({tag, "_c2"}, k);
        tick();
        chk_grant({tag, "_c3"}, k);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk_bubble({tag, "_bub"}, k);
`ifdef MUX16_SCHED_STATS_EN
        chk({tag, "_tmo"}, 32'(bus.timeout), 32'd0);
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.req  = 16'hFFFF;
        bus.done = 1'b0;

        tick();
        tick();
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_gv", 32'(bus.gnt_valid), 32'd0);
`ifdef MUX16_SCHED_STATS_EN
        chk("rst_cnt", 32'(bus.grant_cnt), 32'd0);
`endif

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_grant("first", 4'd0);

        bus.req = 16'h0001;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_grant("hold", 4'd0);
        end
        tick();
        chk_bubble("expire", 4'd0);
`ifdef MUX16_SCHED_STATS_EN
        chk("expire_tmo", 32'(bus.timeout), 32'd1);
`endif
        tick();
        chk_grant("regrant", 4'd0);
`ifdef MUX16_SCHED_STATS_EN
        chk("regrant_tmo", 32'(bus.timeout), 32'd0);
`endif

        bus.req = 16'h8001;
        run3("rr0a", 4'd0);
        tick();
        run3("rr15a", 4'd15);
        tick();
        run3("rr0b", 4'd0);
        tick();
        run3("rr15b", 4'd15);

        bus.req = 16'h0006;
        tick();
        chk_grant("wrap", 4'd1);

        bus.req = 16'h0200;
        tick();
        chk_bubble("drop1", 4'd1);
        tick();
        chk_grant("g9", 4'd9);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(bus.gnt), 32'd0);
        chk("async_gv", 32'(bus.gnt_valid), 32'd0);
        chk("async_sel", 32'(bus.sel), 32'd0);

        bus.req = 16'h0010;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_grant("post_rst", 4'd4);

        bus.req = 16'h0008;
        tick();
        chk_bubble("drop4", 4'd4);
        tick();
        chk_grant("g3a", 4'd3);
        for (int i = 1; i < 8; i++) tick();
        chk_grant("g3a_last", 4'd3);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk_bubble("both", 4'd3);
`ifdef MUX16_SCHED_STATS_EN
        chk("both_tmo", 32'(bus.timeout), 32'd0);
`endif

        bus.req = 16'h0018;
        tick();
        chk_grant("ptr4", 4'd4);

        bus.req = 16'h0008;
        tick();
        chk_bubble("drop4b", 4'd4);
        tick();
        chk_grant("g3b", 4'd3);
        tick();
        chk_grant("g3b_c2", 4'd3);
        bus.req = 16'h0000;
        tick();
        chk_bubble("drop3", 4'd3);
        tick();
        chk_bubble("idle", 4'd3);
`ifdef MUX16_SCHED_STATS_EN
        chk("cnt", 32'(bus.grant_cnt), 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
